// File: rtl/pkt_avg_writer_pkg.sv
// Shared constants for the packet averaging writer: FSM state encodings,
// packet size and accumulator width.
package pkt_avg_writer_pkg;

    localparam int BYTES_PER_PKT = 4;
    localparam int SUM_W         = 10;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_WRITE   = 1'b1;

endpackage

// File: rtl/pkt_avg_writer_avg_calc.sv
// Combinational 4-byte sum to 8-bit mean.
// With AVG_ROUND_EN defined the mean rounds half-up and saturates at 255, otherwise it truncates.
module pkt_avg_calc
    import pkt_avg_writer_pkg::*;
(
    input  logic [SUM_W-1:0] sum_i,
    output logic [7:0]       avg_o
);

`ifdef AVG_ROUND_EN
    logic [SUM_W:0] sum_rnd;
    logic [8:0]     quot;

    // One spare bit so a sum near the top of the range cannot wrap before the shift.
    assign sum_rnd = {1'b0, sum_i} + 11'd2;
    assign quot    = 9'(sum_rnd >> 2);
    assign avg_o   = quot[8] ? 8'hFF : quot[7:0];
`else
    assign avg_o = 8'(sum_i >> 2);
`endif

endmodule

// File: rtl/pkt_avg_writer.sv
// Groups every 4 data bytes of a packet, writes their mean to a result RAM at an
// auto-incrementing address. Rounding mode selected by macro AVG_ROUND_EN (see pkt_avg_calc).
module pkt_avg_writer
    import pkt_avg_writer_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter bit STOP_FULL = 1'b0
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              byte_wr,
    input  logic [7:0]        data_byte,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic [1:0]        byte_idx,
    output logic              full,
    output logic              fsm_state_dbg
);

    // Handshake: byte_wr is a single-cycle strobe with no backpressure; every strobe is
    // consumed on the edge it is seen (except once full). ram_we is a one-cycle strobe
    // with ram_addr/ram_data valid alongside it, and no ready is expected from the RAM.

    logic [0:0]        state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;
    logic              full_q, full_d;

    logic [SUM_W-1:0]  sum_next;
    logic [7:0]        avg;
    logic              accept;

    assign sum_next = sum_q + {2'b00, data_byte};
    assign accept   = byte_wr & ~full_q;

    pkt_avg_calc u_calc (
        .sum_i (sum_next),
        .avg_o (avg)
    );

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        wr_addr_d  = wr_addr_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        full_d     = full_q;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    sum_d = sum_next;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'(BYTES_PER_PKT - 1)) begin
                        state_d    = ST_WRITE;
                        ram_data_d = avg;
                        ram_addr_d = wr_addr_q;
                        idx_d      = 2'd0;
                    end
                end
            end
            ST_WRITE: begin
                state_d   = ST_COLLECT;
                wr_addr_d = wr_addr_q + 1'b1;
                sum_d     = '0;
                idx_d     = 2'd0;
                // The last slot just went out: go full and refuse the overlapping byte.
                if (STOP_FULL && (&wr_addr_q)) begin
                    full_d = 1'b1;
                end else if (byte_wr) begin
                    sum_d = {2'b00, data_byte};
                    idx_d = 2'd1;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_COLLECT;
            sum_q      <= '0;
            idx_q      <= 2'd0;
            wr_addr_q  <= '0;
            ram_addr_q <= '0;
            ram_data_q <= 8'd0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            wr_addr_q  <= wr_addr_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            full_q     <= full_d;
        end
    end

    assign ram_we        = (state_q == ST_WRITE);
    assign ram_addr      = ram_addr_q;
    assign ram_data      = ram_data_q;
    assign byte_idx      = idx_q;
    assign full          = STOP_FULL ? full_q : 1'b0;
    assign fsm_state_dbg = state_q[0];

endmodule

// File: tb/tb_pkt_avg_writer.sv
// Bench for pkt_avg_writer: three instances (default, 4-deep wrapping, 4-deep stop-when-full)
// share one stimulus stream and are checked every cycle against a packet-level model.
module tb_pkt_avg_writer;

    logic       clk_50 = 1'b0;
    logic       reset_n;
    logic       byte_wr;
    logic [7:0] data_byte;

    logic       we0, we1, we2;
    logic [4:0] addr0;
    logic [1:0] addr1, addr2;
    logic [7:0] data0, data1, data2;
    logic [1:0] idx0, idx1, idx2;
    logic       full0, full1, full2;
    logic       dbg0, dbg1, dbg2;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    always #10 clk_50 = ~clk_50;

    pkt_avg_writer #(.ADDR_W(5), .STOP_FULL(1'b0)) dut0 (
        .clk_50(clk_50), .reset_n(reset_n), .byte_wr(byte_wr), .data_byte(data_byte),
        .ram_we(we0), .ram_addr(addr0), .ram_data(data0), .byte_idx(idx0), .full(full0),
        .fsm_state_dbg(dbg0)
    );
    pkt_avg_writer #(.ADDR_W(2), .STOP_FULL(1'b0)) dut1 (
        .clk_50(clk_50), .reset_n(reset_n), .byte_wr(byte_wr), .data_byte(data_byte),
        .ram_we(we1), .ram_addr(addr1), .ram_data(data1), .byte_idx(idx1), .full(full1),
        .fsm_state_dbg(dbg1)
    );
    pkt_avg_writer #(.ADDR_W(2), .STOP_FULL(1'b1)) dut2 (
        .clk_50(clk_50), .reset_n(reset_n), .byte_wr(byte_wr), .data_byte(data_byte),
        .ram_we(we2), .ram_addr(addr2), .ram_data(data2), .byte_idx(idx2), .full(full2),
        .fsm_state_dbg(dbg2)
    );

    // ---------------- reference model ----------------
    int depth[3];
    bit stopf[3];
    int cnt[3];
    int sum[3];
    bit pend[3];
    bit fullm[3];
    int nwr[3];
    int laddr[3];
    int ldata[3];

    // Scoreboard of expected writes (addr/data) for the default instance, plus addr logs.
    logic [12:0] exp_q[$];
    int alog1[$];
    int alog2[$];

    function automatic int model_avg(input int s);
`ifdef AVG_ROUND_EN
        int r;
        r = (s + 2) / 4;
        return (r > 255) ? 255 : r;
`else
        return s / 4;
`endif
    endfunction

    task automatic model_step(input int k, input bit bw, input int db, input bit rst_n);
        if (!rst_n) begin
            cnt[k] = 0; sum[k] = 0; pend[k] = 0; fullm[k] = 0;
            nwr[k] = 0; laddr[k] = 0; ldata[k] = 0;
            if (k == 0) exp_q.delete();
            if (k == 1) alog1.delete();
            if (k == 2) alog2.delete();
            return;
        end
        if (pend[k]) begin
            pend[k] = 0;
            nwr[k]++;
            if (stopf[k] && nwr[k] == depth[k]) fullm[k] = 1;
        end
        if (bw && !fullm[k]) begin
            cnt[k]++;
            sum[k] += db;
            if (cnt[k] == 4) begin
                pend[k]  = 1;
                ldata[k] = model_avg(sum[k]);
                laddr[k] = nwr[k] % depth[k];
                cnt[k]   = 0;
                sum[k]   = 0;
                if (k == 0) exp_q.push_back({5'(laddr[k]), 8'(ldata[k])});
                if (k == 1) alog1.push_back(laddr[k]);
                if (k == 2) alog2.push_back(laddr[k]);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input int k, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] idx, input logic fl);
        chk($sformatf("ram_we[%0d]", k), 32'(we), 32'(pend[k]));
        chk($sformatf("ram_addr[%0d]", k), addr, 32'(laddr[k]));
        chk($sformatf("ram_data[%0d]", k), data, 32'(ldata[k]));
        chk($sformatf("byte_idx[%0d]", k), idx, 32'(cnt[k]));
        chk($sformatf("full[%0d]", k), 32'(fl), 32'(fullm[k]));
    endtask

    // One compare process: advance the model on each edge, check all outputs 1 ns later.
    initial begin
        bit s_bw;
        int s_db;
        bit s_rst;
        forever begin
            @(posedge clk_50);
            s_bw  = byte_wr;
            s_db  = int'(data_byte);
            s_rst = reset_n;
            for (int k = 0; k < 3; k++) model_step(k, s_bw, s_db, s_rst);
            #1;
            compare(0, we0, 32'(addr0), 32'(data0), 32'(idx0), full0);
            compare(1, we1, 32'(addr1), 32'(data1), 32'(idx1), full1);
            compare(2, we2, 32'(addr2), 32'(data2), 32'(idx2), full2);
        end
    end

    // ---------------- driver tasks (called on a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_wr   = 1'b1;
        data_byte = b;
        @(negedge clk_50);
        byte_wr   = 1'b0;
        repeat (gap) @(negedge clk_50);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int gap);
        send_byte(b0, gap);
        send_byte(b1, gap);
        send_byte(b2, gap);
        send_byte(b3, gap);
        repeat (3) @(negedge clk_50);
    endtask

    task automatic do_reset();
        #5 reset_n = 1'b0;
        @(negedge clk_50);
        @(negedge clk_50);
        reset_n = 1'b1;
        @(negedge clk_50);
    endtask

    logic [7:0] t1_bytes[4];
    logic [7:0] t3_bytes[8];

    initial begin
        depth = '{32, 4, 4};
        stopf = '{1'b0, 1'b0, 1'b1};
        reset_n   = 1'b0;
        byte_wr   = 1'b0;
        data_byte = 8'd0;
        repeat (3) @(negedge clk_50);
        chk("reset_ram_we", 32'(we0), 32'd0);
        chk("reset_byte_idx", 32'(idx0), 32'd0);
        reset_n = 1'b1;
        @(negedge clk_50);

        // Test 1: spaced bytes 10,20,30,40 -> 25 at address 0, byte_idx walks 1,2,3,0.
        t1_bytes = '{8'd10, 8'd20, 8'd30, 8'd40};
        for (int i = 0; i < 4; i++) begin
            send_byte(t1_bytes[i], 8);
            chk("t1_byte_idx", 32'(idx0), 32'((i + 1) % 4));
        end
        chk("t1_writes", 32'(exp_q.size()), 32'd1);
        chk("t1_exp", 32'(exp_q[0]), 32'({5'd0, 8'd25}));

        // Test 2: rounding-sensitive packet and a flat packet.
        do_reset();
        send_pkt(8'd1, 8'd1, 8'd2, 8'd2, 1);
`ifdef AVG_ROUND_EN
        chk("t2_avg_1122", 32'(exp_q[0]), 32'({5'd0, 8'd2}));
`else
        chk("t2_avg_1122", 32'(exp_q[0]), 32'({5'd0, 8'd1}));
`endif
        send_pkt(8'd127, 8'd127, 8'd127, 8'd127, 0);
        chk("t2_avg_127", 32'(exp_q[1]), 32'({5'd1, 8'd127}));
        chk("t2_dut_data", 32'(data0), 32'd127);

        // Test 3: eight back-to-back bytes; the 5th lands during the write cycle.
        do_reset();
        t3_bytes = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd9, 8'd9, 8'd9, 8'd9};
        for (int i = 0; i < 8; i++) send_byte(t3_bytes[i], 0);
        repeat (3) @(negedge clk_50);
        chk("t3_writes", 32'(exp_q.size()), 32'd2);
        chk("t3_first", 32'(exp_q[0]), 32'({5'd0, 8'd5}));
        chk("t3_second", 32'(exp_q[1]), 32'({5'd1, 8'd9}));
        chk("t3_dut_addr", 32'(addr0), 32'd1);

        // Test 4: reset mid-packet discards the partial packet.
        do_reset();
        send_byte(8'd200, 1);
        send_byte(8'd100, 1);
        do_reset();
        chk("t4_idx_after_reset", 32'(idx0), 32'd0);
        send_pkt(8'd8, 8'd8, 8'd8, 8'd8, 2);
        chk("t4_writes", 32'(exp_q.size()), 32'd1);
        chk("t4_write", 32'(exp_q[0]), 32'({5'd0, 8'd8}));

        // Tests 5 and 6: five packets on the 4-deep instances.
        do_reset();
        for (int p = 0; p < 5; p++) send_pkt(8'(p), 8'(p + 1), 8'(p + 2), 8'(p + 3), 1);
        chk("t5_writes", 32'(alog1.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("t5_addr", 32'(alog1[i]), 32'(i % 4));
        chk("t5_full", 32'(full1), 32'd0);
        chk("t6_writes", 32'(alog2.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t6_addr", 32'(alog2[i]), 32'(i));
        chk("t6_full", 32'(full2), 32'd1);
        send_byte(8'd77, 0);
        chk("t6_idx_held", 32'(idx2), 32'd0);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            byte_wr   = ($urandom_range(0, 3) != 0);
            data_byte = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 599) == 0) begin
                #5 reset_n = 1'b0;
                @(negedge clk_50);
                reset_n = 1'b1;
            end else begin
                @(negedge clk_50);
            end
        end
        byte_wr = 1'b0;
        repeat (4) @(negedge clk_50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
